// File: rtl/alu_muldiv_unit_if.sv
// Request/response bundle between the datapath controller and the execution unit.
interface alu_muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [5:0]       Signal;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [WIDTH-1:0] Output;
  logic             busy;
  logic             done;
  logic             div_zero;

  // Controller side: issues requests, observes results and status.
  modport master (
    output start, Signal, dataA, dataB,
    input  Output, busy, done, div_zero
  );

  // Execution unit side.
  modport slave (
    input  start, Signal, dataA, dataB,
    output Output, busy, done, div_zero
  );
endinterface

// File: rtl/alu_muldiv_unit.sv
// Execution unit: single-cycle ALU/shift ops, iterative MULTU/DIVU into HI/LO, MFHI/MFLO readback.
module alu_muldiv_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  alu_muldiv_unit_if.slave   bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_SLT   = 6'd42;

  localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               dz_q, dz_d;
  // op: multiplicand for MULTU, divisor for DIVU
  logic [WIDTH-1:0]   op_q, op_d;
  // wrk_hi: partial product / partial remainder; wrk_lo: multiplier / dividend->quotient
  logic [WIDTH:0]     wrk_hi_q, wrk_hi_d;
  logic [WIDTH-1:0]   wrk_lo_q, wrk_lo_d;

  logic [WIDTH-1:0]   mul_add;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_tmp;
  logic [WIDTH:0]     div_rem;
  logic               div_ge;
  logic [WIDTH:0]     step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic               accept;

  // One iteration of shift-add multiply or restoring divide on the working registers.
  always_comb begin
    mul_add = wrk_lo_q[0] ? op_q : '0;
    mul_sum = {1'b0, wrk_hi_q[WIDTH-1:0]} + {1'b0, mul_add};
    div_tmp = {wrk_hi_q[WIDTH-1:0], wrk_lo_q[WIDTH-1]};
    div_ge  = (div_tmp >= {1'b0, op_q});
    div_rem = div_ge ? (div_tmp - {1'b0, op_q}) : div_tmp;
    if (state_q == ST_DIV) begin
      step_hi = div_rem;
      step_lo = {wrk_lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = {1'b0, mul_sum[WIDTH:1]};
      step_lo = {mul_sum[0], wrk_lo_q[WIDTH-1:1]};
    end
  end

  // Next-state, result and status logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    out_d    = out_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    op_d     = op_q;
    wrk_hi_d = wrk_hi_q;
    wrk_lo_d = wrk_lo_q;
    accept   = bus.start && !busy_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          dz_d   = 1'b0;
          done_d = 1'b1;
          case (bus.Signal)
            F_AND:  out_d = bus.dataA & bus.dataB;
            F_OR:   out_d = bus.dataA | bus.dataB;
            F_ADD:  out_d = bus.dataA + bus.dataB;
            F_SUB:  out_d = bus.dataA - bus.dataB;
            F_SLT: begin
              out_d    = '0;
              out_d[0] = ($signed(bus.dataA) < $signed(bus.dataB));
            end
            F_SLL:  out_d = bus.dataA << bus.dataB[SHAMT_W-1:0];
            F_SRL:  out_d = bus.dataA >> bus.dataB[SHAMT_W-1:0];
            F_MFHI: out_d = hi_q;
            F_MFLO: out_d = lo_q;
            F_MULTU: begin
              state_d  = ST_MUL;
              cnt_d    = '0;
              op_d     = bus.dataA;
              wrk_hi_d = '0;
              wrk_lo_d = bus.dataB;
              done_d   = 1'b0;
            end
            F_DIVU: begin
              if (bus.dataB == '0) begin
                hi_d = bus.dataA;
                lo_d = '1;
                dz_d = 1'b1;
              end else begin
                state_d  = ST_DIV;
                cnt_d    = '0;
                op_d     = bus.dataB;
                wrk_hi_d = '0;
                wrk_lo_d = bus.dataA;
                done_d   = 1'b0;
              end
            end
            default: out_d = '0;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        wrk_hi_d = step_hi;
        wrk_lo_d = step_lo;
        cnt_d    = cnt_q + SHAMT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = ST_IDLE;
          hi_d    = step_hi[WIDTH-1:0];
          lo_d    = step_lo;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; synchronous reset aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      dz_q     <= 1'b0;
      op_q     <= '0;
      wrk_hi_q <= '0;
      wrk_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      out_q    <= out_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      dz_q     <= dz_d;
      op_q     <= op_d;
      wrk_hi_q <= wrk_hi_d;
      wrk_lo_q <= wrk_lo_d;
    end
  end

  assign bus.Output   = out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;

endmodule

// File: doc/alu_muldiv_unit.md
Name: alu_muldiv_unit

Overview:
Parametrised execution unit for the MIPS-style datapath, next generation of the ALU / shifter / divider / HI-LO / output-mux cluster.
- Single-cycle logic, arithmetic and shift ops.
- Multi-cycle unsigned multiply (MULTU) and divide (DIVU), both writing internal HI/LO registers.
- MFHI/MFLO readback.
- Uses a start/busy/done handshake so the controlling datapath can stall on long operations.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, >= 8.
- SHAMT_W, 5, shift-amount bits taken from dataB[SHAMT_W-1:0]; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- Signal  input  6  MIPS funct code selecting the operation.
- dataA  input  WIDTH  operand A (rs).
- dataB  input  WIDTH  operand B (rt); also carries the shift amount.
- Output  output  WIDTH  registered result.
- busy  output  1  multi-cycle operation in progress.
- done  output  1  one-cycle pulse: operation complete.
- div_zero  output  1  last DIVU had dataB=0; sticky until the next accepted start.

Behaviour:
- Reset (synchronous, highest priority; also aborts any operation in progress):
  - Output=0, HI=0, LO=0, busy=0, done=0, div_zero=0, FSM=IDLE, iteration counter=0.
  - start asserted in the same cycle as reset is ignored.
- Acceptance: start=1 and busy=0 at a rising edge (cycle 0). start while busy=1 is ignored; no queueing.
- Funct codes and results (single-cycle ops: Output written at the acceptance edge, done=1 in cycle 1):
  - AND 36: A&B.
  - OR 37: A|B.
  - ADD 32: A+B modulo 2^WIDTH; no overflow flag.
  - SUB 34: A-B modulo 2^WIDTH; no overflow flag.
  - SLT 42: 1 if signed A < signed B, else 0; zero-extended to WIDTH.
  - SLL 0: A << B[SHAMT_W-1:0], zero fill.
  - SRL 2: A >> B[SHAMT_W-1:0], zero fill.
  - MFHI 16: Output=HI.
  - MFLO 18: Output=LO.
  - Any other code: Output=0, done pulses, HI/LO unchanged.
- MULTU 25:
  - Unsigned shift-add, one bit per cycle. Operands latched at acceptance; later changes on dataA/dataB have no effect.
  - FSM IDLE->MUL. busy=1 in cycles 1..WIDTH.
  - At the edge ending cycle WIDTH: {HI,LO} = A*B (2*WIDTH bits), FSM->IDLE, busy=0, done=1 in cycle WIDTH+1.
  - Output holds its previous value.
- DIVU 27:
  - Unsigned restoring division, one quotient bit per cycle, same timing as MULTU (FSM IDLE->DIV).
  - Result: LO=quotient, HI=remainder. div_zero cleared.
  - Divide by zero (dataB=0 at acceptance):
    - No iteration; busy stays 0.
    - At the acceptance edge: HI=dataA, LO=all ones, div_zero=1.
    - done=1 in cycle 1.
- FSM states: IDLE, MUL, DIV.
  - IDLE->MUL/DIV on an accepted MULTU/DIVU.
  - MUL/DIV->IDLE when the counter reaches WIDTH-1 on the last iteration.
  - Counter resets to 0 on every acceptance.
- done is high for exactly one cycle per accepted operation, and never while busy=1.
- A new start is accepted in the same cycle that done=1, since busy=0 then; back-to-back operations allowed.
- HI/LO change only on MULTU/DIVU completion, divide-by-zero, or reset.
- div_zero clears on any accepted start other than a divide by zero.

Test Plan:
1. Single-cycle ops, WIDTH=32:
   - reset, then start ADD A=0xFFFFFFFF B=2 -> cycle 1: Output=0x00000001, done=1.
   - SLT A=0xFFFFFFFE B=1 -> Output=1.
   - SLL A=1 B=31 -> Output=0x80000000.
2. MULTU A=0xFFFFFFFF B=2:
   - busy=1 for exactly 32 cycles; done in cycle 33.
   - Then MFHI -> Output=0x00000001; MFLO -> Output=0xFFFFFFFE.
3. DIVU A=100 B=7 -> after 32 busy cycles: HI=2, LO=14, div_zero=0, checked via MFHI/MFLO.
4. DIVU A=0x1234 B=0:
   - busy stays 0; done in cycle 1; div_zero=1.
   - MFLO -> 0xFFFFFFFF; MFHI -> 0x1234.
   - Next ADD clears div_zero.
5. Start during busy and reset mid-op:
   - During DIVU, pulse start with AND at cycle 10 -> ignored: no extra done, HI/LO=DIVU result.
   - Reset at cycle 15 of a second DIVU -> next cycle: busy=0, done=0, HI=LO=0, Output=0.
6. Back-to-back: start MFLO in the same cycle MULTU done=1 -> accepted; Output=new LO in the following cycle.
